// File: rtl/nn_pkg.sv
// Shared state encoding, register map and Q16.16 saturating add for the
// bias/ReLU writeback stage.
package nn_pkg;

   localparam int Q_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_RES  = 3'd1,
      ST_REQ_BIAS  = 3'd2,
      ST_WAIT_BIAS = 3'd3,
      ST_WRITE     = 3'd4
   } state_t;

   localparam logic [3:0] REG_CTRL      = 4'd0;
   localparam logic [3:0] REG_BIAS_BASE = 4'd1;
   localparam logic [3:0] REG_OUT_BASE  = 4'd2;
   localparam logic [3:0] REG_COUNT     = 4'd3;
   localparam logic [3:0] REG_RELU      = 4'd4;

   localparam logic [Q_W-1:0] Q_MAX = 32'h7FFF_FFFF;
   localparam logic [Q_W-1:0] Q_MIN = 32'h8000_0000;

   // One guard bit is enough: overflow shows up as the two top bits differing.
   function automatic logic [Q_W-1:0] sat_add(input logic [Q_W-1:0] a,
                                              input logic [Q_W-1:0] b);
      logic [Q_W:0] sum;
      sum = {a[Q_W-1], a} + {b[Q_W-1], b};
      if (sum[Q_W] != sum[Q_W-1]) begin
         sat_add = sum[Q_W] ? Q_MIN : Q_MAX;
      end else begin
         sat_add = sum[Q_W-1:0];
      end
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small show-ahead FIFO buffering dot-product results ahead of the bias fetch.
module sync_fifo #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              w_do_push;
   logic              w_do_pop;

   // A pop frees a slot in the same cycle, so a full FIFO may still accept.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);
   assign full      = (r_count == (AW+1)'(FIFO_DEPTH));
   assign empty     = (r_count == '0);
   assign pop_data  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/bias_relu_writeback.sv
// Adds a fetched bias to each dot-product result, saturates, optionally applies
// ReLU and writes the activation out; one neuron in flight at a time.
module bias_relu_writeback
   import nn_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              slave_waitrequest,
   input  logic [3:0]        slave_address,
   input  logic              slave_read,
   output logic [DATA_W-1:0] slave_readdata,
   input  logic              slave_write,
   input  logic [DATA_W-1:0] slave_writedata,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic [DATA_W-1:0] res_data,
   input  logic              master_waitrequest,
   output logic [31:0]       master_address,
   output logic              master_read,
   input  logic [DATA_W-1:0] master_readdata,
   input  logic              master_readdatavalid,
   input  logic              master2_waitrequest,
   output logic [31:0]       master2_address,
   output logic              master2_write,
   output logic [DATA_W-1:0] master2_writedata
);

   state_t            r_state;
   state_t            w_state_next;
   logic [31:0]       r_idx;
   logic              r_busy;
   logic              r_done;
   logic [31:0]       r_bias_base;
   logic [31:0]       r_out_base;
   logic [31:0]       r_count;
   logic              r_relu_en;
   logic [31:0]       r_act_bias_base;
   logic [31:0]       r_act_out_base;
   logic [31:0]       r_act_count;
   logic              r_act_relu_en;
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_result;

   logic              w_start;
   logic              w_last;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [DATA_W-1:0] w_fifo_data;
   logic [DATA_W-1:0] w_sum_sat;
   logic [DATA_W-1:0] w_result;
   logic              w_unused;

   assign slave_waitrequest = 1'b0;
   assign w_unused          = slave_read;

   assign res_ready = !rst && !w_full;
   assign w_push    = res_valid && res_ready;

   sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data (res_data),
      .pop       (w_pop),
      .pop_data  (w_fifo_data),
      .full      (w_full),
      .empty     (w_empty)
   );

   assign w_start   = slave_write && (slave_address == REG_CTRL) && (r_state == ST_IDLE);
   assign w_last    = ((r_idx + 32'd1) == r_act_count);
   assign w_sum_sat = sat_add(r_acc, master_readdata);
   assign w_result  = (r_act_relu_en && w_sum_sat[DATA_W-1]) ? '0 : w_sum_sat;

   always_comb begin
      slave_readdata = '0;
      case (slave_address)
         REG_CTRL:      slave_readdata = {30'b0, r_done, r_busy};
         REG_BIAS_BASE: slave_readdata = r_bias_base;
         REG_OUT_BASE:  slave_readdata = r_out_base;
         REG_COUNT:     slave_readdata = r_count;
         REG_RELU:      slave_readdata = {31'b0, r_relu_en};
         default:       ;
      endcase
   end

   // Bus outputs are forced quiet during reset so an abandoned request never lingers.
   always_comb begin
      w_state_next      = r_state;
      w_pop             = 1'b0;
      master_read       = 1'b0;
      master_address    = '0;
      master2_write     = 1'b0;
      master2_address   = '0;
      master2_writedata = '0;
      if (!rst) begin
         case (r_state)
            ST_IDLE: begin
               if (w_start && (r_count != 32'd0)) begin
                  w_state_next = ST_WAIT_RES;
               end
            end
            ST_WAIT_RES: begin
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_state_next = ST_REQ_BIAS;
               end
            end
            ST_REQ_BIAS: begin
               master_read    = 1'b1;
               master_address = r_act_bias_base + (r_idx << 2);
               if (!master_waitrequest) begin
                  w_state_next = ST_WAIT_BIAS;
               end
            end
            ST_WAIT_BIAS: begin
               if (master_readdatavalid) begin
                  w_state_next = ST_WRITE;
               end
            end
            ST_WRITE: begin
               master2_write     = 1'b1;
               master2_address   = r_act_out_base + (r_idx << 2);
               master2_writedata = r_result;
               if (!master2_waitrequest) begin
                  w_state_next = w_last ? ST_IDLE : ST_WAIT_RES;
               end
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_idx           <= '0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_bias_base     <= '0;
         r_out_base      <= '0;
         r_count         <= '0;
         r_relu_en       <= 1'b0;
         r_act_bias_base <= '0;
         r_act_out_base  <= '0;
         r_act_count     <= '0;
         r_act_relu_en   <= 1'b0;
         r_acc           <= '0;
         r_result        <= '0;
      end else begin
         r_state <= w_state_next;
         // Config writes land any time; the running job uses the copies taken at start.
         if (slave_write) begin
            case (slave_address)
               REG_BIAS_BASE: r_bias_base <= slave_writedata;
               REG_OUT_BASE:  r_out_base  <= slave_writedata;
               REG_COUNT:     r_count     <= slave_writedata;
               REG_RELU:      r_relu_en   <= slave_writedata[0];
               default:       ;
            endcase
         end
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_idx           <= '0;
                  r_busy          <= (r_count != 32'd0);
                  r_done          <= (r_count == 32'd0);
                  r_act_bias_base <= r_bias_base;
                  r_act_out_base  <= r_out_base;
                  r_act_count     <= r_count;
                  r_act_relu_en   <= r_relu_en;
               end
            end
            ST_WAIT_RES: begin
               if (w_pop) begin
                  r_acc <= w_fifo_data;
               end
            end
            ST_WAIT_BIAS: begin
               if (master_readdatavalid) begin
                  r_result <= w_result;
               end
            end
            ST_WRITE: begin
               if (!master2_waitrequest) begin
                  r_idx <= r_idx + 32'd1;
                  if (w_last) begin
                     r_busy <= 1'b0;
                     r_done <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/bias_relu_writeback.md
Name: bias_relu_writeback

Overview:
Output stage placed directly downstream of the dot-product accelerator. It accepts one Q16.16 dot-product result per neuron on a valid/ready stream and fetches the matching Q16.16 bias from SDRAM. It adds the bias with signed saturation and optionally applies ReLU. It then writes the output activation to the SRAM bank the next layer reads from. The CPU configures and starts it through a small register slave.

Parameters:
FIFO_DEPTH, 4, result buffer entries (power of two, >=2)
DATA_W, 32, datapath and bus width (Q16.16 signed)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
slave_waitrequest  out  1  held 0; registers are always ready
slave_address  in  4  word index
slave_read  in  1  register read strobe
slave_readdata  out  32  register read data, combinational from slave_address
slave_write  in  1  register write strobe
slave_writedata  in  32  register write data
res_valid  in  1  dot-product result valid
res_ready  out  1  FIFO not full
res_data  in  32  Q16.16 dot-product result
master_waitrequest  in  1  SDRAM stall
master_address  out  32  bias byte address
master_read  out  1  bias read request
master_readdata  in  32  bias data
master_readdatavalid  in  1  bias data valid
master2_waitrequest  in  1  SRAM stall
master2_address  out  32  activation byte address
master2_write  out  1  activation write request
master2_writedata  out  32  activation data

Behaviour:
Register map:
- 0: write any value = start, ignored while busy. Read = {30'b0, done, busy}.
- 1: bias_base
- 2: out_base
- 3: count (number of neurons)
- 4: bit0 relu_en
- Other addresses: writes ignored, reads return 0.
- Registers 1-4 can be written while busy; the new values take effect at the next start.

Reset (rst=1 on a clk edge):
- State goes to IDLE.
- Index, busy, done and all config registers clear to 0.
- FIFO is flushed.
- All master outputs drive 0.
- res_ready is 0 during the reset cycle and 1 afterwards.
- Reset mid-operation abandons the outstanding request with no further bus activity. A late readdatavalid is ignored because it only counts in WAIT_BIAS.

FIFO:
- Push when res_valid && res_ready.
- Pop only in WAIT_RES.
- A push and a pop in the same cycle on a full FIFO is allowed and the occupancy stays the same.
- The FIFO accepts data in IDLE too, so the upstream unit may finish before start.

State machine:
- IDLE: on start, set idx=0, busy=1, done=0. If count==0, set busy=0, done=1 and stay in IDLE. Otherwise go to WAIT_RES.
- WAIT_RES: if the FIFO is non-empty, pop into acc and go to REQ_BIAS.
- REQ_BIAS: master_read=1, master_address=bias_base+4*idx. Hold until master_waitrequest=0, then go to WAIT_BIAS.
- WAIT_BIAS: on master_readdatavalid, compute sum=acc+readdata and register it, then go to WRITE. Exactly one read is ever outstanding.
- WRITE: master2_write=1, master2_address=out_base+4*idx, master2_writedata=result. Hold the address and data stable until master2_waitrequest=0. Then idx++. If idx+1==count, set busy=0, done=1 and go to IDLE. Otherwise go to WAIT_RES.

Arithmetic:
- Sum is 33-bit signed.
- If it is above 0x7FFFFFFF it saturates to 0x7FFFFFFF; if it is below 0x80000000 it saturates to 0x80000000.
- ReLU then forces negative results to 0 when relu_en=1.
- Address arithmetic wraps modulo 2^32.
- Minimum latency per neuron, with no stalls and readdatavalid one cycle after the request: 4 cycles.

Decomposition:
- Shared package nn_pkg: state enum, register address constants (REG_CTRL..REG_RELU), Q16.16 saturation limits, and a sat_add function.
- Sub-module: sync_fifo (parameterised DATA_W/FIFO_DEPTH, push/pop/full/empty, synchronous active-high reset).

Test Plan:
- bias_base=0x1000, out_base=0x2000, count=3, relu_en=0. Results 0x00010000, 0x00020000, 0xFFFF0000; biases 0x00008000, 0xFFFF0000, 0x00000000 -> writes 0x00018000@0x2000, 0x00010000@0x2004, 0xFFFF0000@0x2008; status reads 0x2.
- Same run with relu_en=1 -> third write is 0x00000000.
- Result 0x7FFF0000 + bias 0x00020000 -> 0x7FFFFFFF. Result 0x80010000 + bias 0xFFFE0000 (relu off) -> 0x80000000.
- Random master_waitrequest and master2_waitrequest stalls of 0-5 cycles, with res_valid arriving before start and the FIFO going full (res_ready=0 after 4 pushes) -> all data correct and in order, no lost or duplicated writes, address and data stable during stalls.
- count=0 start -> no bus activity, done=1 on the next cycle. A write to register 0 while busy -> ignored.
- rst asserted while in WAIT_BIAS, then a late readdatavalid -> no write issued, status=0, FIFO empty; a subsequent full run is correct.
